// File: rtl/aes_pkg.sv
// Shared Rijndael helpers for the ShiftRows round stage.
// Byte k sits at state[W-1-8k -: 8], row k%4, column k/4.
package aes_pkg;

  localparam int NB_LEGAL_A = 4;
  localparam int NB_LEGAL_B = 6;
  localparam int NB_LEGAL_C = 8;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 4;

  function automatic bit nb_legal(int nb);
    return nb == NB_LEGAL_A ||
           nb == NB_LEGAL_B ||
           nb == NB_LEGAL_C;
  endfunction

  function automatic bit stages_legal(int s);
    return s >= STAGES_MIN && s <= STAGES_MAX;
  endfunction

  // 256-bit blocks spread rows 2 and 3 one column further.
  function automatic int row_off(int r, int nb);
    if (nb == 8 && r >= 2) return r + 1;
    return r;
  endfunction

  function automatic int byte_msb(int r, int c, int nb);
    return 32 * nb - 1 - 8 * (4 * c + r);
  endfunction

  function automatic int src_col(int r, int c, int nb,
                                 bit dec);
    if (dec) return (c - row_off(r, nb) + nb) % nb;
    return (c + row_off(r, nb)) % nb;
  endfunction

endpackage

// File: rtl/aes_shift_rows_pipe_if.sv
// Valid/ready beat bundle for the pipelined ShiftRows stage.
// AES_SHIFT_ROWS_TAG_EN adds a sideband tag in and out.
interface aes_shift_rows_pipe_if #(
  parameter int W = 128
`ifdef AES_SHIFT_ROWS_TAG_EN
  , parameter int TAG_W = 4
`endif
);

  logic         valid_in;
  logic         ready_in;
  logic         decrypt_in;
  logic [W-1:0] state_in;
  logic         valid_out;
  logic         ready_out;
  logic [W-1:0] state_out;
  logic         busy;
`ifdef AES_SHIFT_ROWS_TAG_EN
  logic [TAG_W-1:0] tag_in;
  logic [TAG_W-1:0] tag_out;
`endif

  modport master (
    output valid_in, decrypt_in, state_in,
    output ready_out,
`ifdef AES_SHIFT_ROWS_TAG_EN
    output tag_in,
    input  tag_out,
`endif
    input  ready_in, valid_out, state_out, busy
  );

  modport slave (
    input  valid_in, decrypt_in, state_in,
    input  ready_out,
`ifdef AES_SHIFT_ROWS_TAG_EN
    input  tag_in,
    output tag_out,
`endif
    output ready_in, valid_out, state_out, busy
  );

endinterface

// File: rtl/aes_shift_rows_pipe_comb.sv
// Combinational ShiftRows / InvShiftRows byte permutation.
// Pure wiring; the decrypt select picks between two fixed maps.
module aes_shift_rows_comb
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic              decrypt,
  input  logic [32*NB-1:0]  state_in,
  output logic [32*NB-1:0]  state_out
);

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < NB; c++) begin : g_col
      localparam int DST = byte_msb(r, c, NB);
      localparam int ENC =
        byte_msb(r, src_col(r, c, NB, 1'b0), NB);
      localparam int DEC =
        byte_msb(r, src_col(r, c, NB, 1'b1), NB);
      assign state_out[DST -: 8] = decrypt
        ? state_in[DEC -: 8]
        : state_in[ENC -: 8];
    end
  end

endmodule

// File: rtl/aes_shift_rows_pipe.sv
// Pipelined ShiftRows / InvShiftRows with STAGES elastic registers.
// Optional tag sideband: define AES_SHIFT_ROWS_TAG_EN.
module aes_shift_rows_pipe
  import aes_pkg::*;
#(
  parameter int NB     = 4,
  parameter int STAGES = 1,
  parameter int TAG_W  = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  aes_shift_rows_pipe_if.slave   bus
);

  localparam int W = 32 * NB;

  if (!nb_legal(NB)) begin : g_bad_nb
    $error("aes_shift_rows_pipe: NB must be 4, 6 or 8");
  end
  if (!stages_legal(STAGES)) begin : g_bad_stages
    $error("aes_shift_rows_pipe: STAGES must be 1..4");
  end
  if (TAG_W < 1) begin : g_bad_tag
    $error("aes_shift_rows_pipe: TAG_W must be >= 1");
  end

  logic [W-1:0]        shifted;
  logic [W-1:0]        data_q [STAGES];
  logic [STAGES-1:0]   valid_q;
  logic [STAGES-1:0]   load;

  aes_shift_rows_comb #(.NB(NB)) u_comb (
    .decrypt   (bus.decrypt_in),
    .state_in  (bus.state_in),
    .state_out (shifted)
  );

  // A stage may load iff some stage at or after it is empty,
  // or the consumer is taking the last beat.
  always_comb begin
    logic hole;
    load = '0;
    for (int i = 0; i < STAGES; i++) begin
      hole = bus.ready_out;
      for (int j = i; j < STAGES; j++) begin
        if (!valid_q[j]) hole = 1'b1;
      end
      load[i] = hole;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      if (load[0]) begin
        valid_q[0] <= bus.valid_in;
        if (bus.valid_in) data_q[0] <= shifted;
      end
      for (int i = 1; i < STAGES; i++) begin
        if (load[i]) begin
          valid_q[i] <= valid_q[i-1];
          if (valid_q[i-1]) data_q[i] <= data_q[i-1];
        end
      end
    end
  end

`ifdef AES_SHIFT_ROWS_TAG_EN
  logic [TAG_W-1:0] tag_q [STAGES];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < STAGES; i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      if (load[0] && bus.valid_in) tag_q[0] <= bus.tag_in;
      for (int i = 1; i < STAGES; i++) begin
        if (load[i] && valid_q[i-1]) tag_q[i] <= tag_q[i-1];
      end
    end
  end

  assign bus.tag_out = tag_q[STAGES-1];
`endif

  assign bus.ready_in  = load[0];
  assign bus.valid_out = valid_q[STAGES-1];
  assign bus.state_out = data_q[STAGES-1];
  assign bus.busy      = |valid_q;

endmodule

// File: tb/tb_aes_shift_rows_pipe.sv
// Self-checking bench: three pipe configurations against a row-rotation model.
// Scoreboard also checks ready_in/busy against beat occupancy every cycle.
module tb_aes_shift_rows_pipe;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  aes_shift_rows_pipe_if #(.W(128)) if_a ();
  aes_shift_rows_pipe_if #(.W(128)) if_b ();
  aes_shift_rows_pipe_if #(.W(256)) if_c ();

  aes_shift_rows_pipe #(.NB(4), .STAGES(1)) u_a (
    .clk(clk), .reset(reset), .bus(if_a));
  aes_shift_rows_pipe #(.NB(4), .STAGES(3)) u_b (
    .clk(clk), .reset(reset), .bus(if_b));
  aes_shift_rows_pipe #(.NB(8), .STAGES(2)) u_c (
    .clk(clk), .reset(reset), .bus(if_c));

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [255:0] got,
                     logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Model: build rows, rotate each row by its offset, repack.
  function automatic logic [255:0] ref_shift(
      input logic [255:0] s, input int nb, input bit dec);
    logic [7:0]   row [4][8];
    logic [7:0]   t;
    logic [255:0] o;
    int           off;
    o = '0;
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        row[r][c] = s[32*nb-1-8*(4*c+r) -: 8];
    for (int r = 0; r < 4; r++) begin
      case (r)
        0: off = 0;
        1: off = 1;
        2: off = (nb == 8) ? 3 : 2;
        default: off = (nb == 8) ? 4 : 3;
      endcase
      repeat (off) begin
        if (!dec) begin
          t = row[r][0];
          for (int c = 0; c < nb - 1; c++) row[r][c] = row[r][c+1];
          row[r][nb-1] = t;
        end else begin
          t = row[r][nb-1];
          for (int c = nb - 1; c > 0; c--) row[r][c] = row[r][c-1];
          row[r][0] = t;
        end
      end
    end
    for (int c = 0; c < nb; c++)
      for (int r = 0; r < 4; r++)
        o[32*nb-1-8*(4*c+r) -: 8] = row[r][c];
    return o;
  endfunction

  logic [255:0] sq [3][$];
  int           held [3];
  bit           stall [3];
  logic [255:0] hold_d [3];
  int           stg [3] = '{1, 3, 2};
  int           nbs [3] = '{4, 4, 8};

  always @(negedge clk) begin
    bit           vi [3], ri [3], dc [3];
    bit           vo [3], ro [3], by [3];
    logic [255:0] si [3], so [3];
    vi[0] = if_a.valid_in;  ri[0] = if_a.ready_in;
    dc[0] = if_a.decrypt_in; si[0] = 256'(if_a.state_in);
    vo[0] = if_a.valid_out; ro[0] = if_a.ready_out;
    so[0] = 256'(if_a.state_out); by[0] = if_a.busy;
    vi[1] = if_b.valid_in;  ri[1] = if_b.ready_in;
    dc[1] = if_b.decrypt_in; si[1] = 256'(if_b.state_in);
    vo[1] = if_b.valid_out; ro[1] = if_b.ready_out;
    so[1] = 256'(if_b.state_out); by[1] = if_b.busy;
    vi[2] = if_c.valid_in;  ri[2] = if_c.ready_in;
    dc[2] = if_c.decrypt_in; si[2] = if_c.state_in;
    vo[2] = if_c.valid_out; ro[2] = if_c.ready_out;
    so[2] = if_c.state_out; by[2] = if_c.busy;
    for (int d = 0; d < 3; d++) begin
      if (reset) begin
        sq[d].delete();
        held[d] = 0;
        stall[d] = 1'b0;
      end else begin
        chk($sformatf("busy%0d", d), 256'(by[d]),
            256'(held[d] != 0));
        chk($sformatf("ready_in%0d", d), 256'(ri[d]),
            256'(held[d] < stg[d] || ro[d]));
        if (stall[d]) begin
          chk($sformatf("hold_valid%0d", d), 256'(vo[d]), 256'(1));
          chk($sformatf("hold_data%0d", d), so[d], hold_d[d]);
        end
        if (vi[d] && ri[d])
          sq[d].push_back(ref_shift(si[d], nbs[d], dc[d]));
        if (vo[d] && ro[d]) begin
          if (sq[d].size() == 0)
            chk($sformatf("unexpected_out%0d", d),
                256'(vo[d]), 256'(0));
          else
            chk($sformatf("out%0d", d), so[d], sq[d].pop_front());
        end
        held[d] += int'(vi[d] && ri[d]) - int'(vo[d] && ro[d]);
        stall[d] = vo[d] && !ro[d];
        hold_d[d] = so[d];
      end
    end
  end

  initial begin
    logic [255:0] s8, m;
    logic [127:0] sa;
    int first, nvalid, n, s;
    bit acc;
    if_a.valid_in = 0; if_a.decrypt_in = 0;
    if_a.state_in = '0; if_a.ready_out = 1;
    if_b.valid_in = 0; if_b.decrypt_in = 0;
    if_b.state_in = '0; if_b.ready_out = 1;
    if_c.valid_in = 0; if_c.decrypt_in = 0;
    if_c.state_in = '0; if_c.ready_out = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_valid", 256'(if_a.valid_out), 256'(0));
    chk("rst_a_state", 256'(if_a.state_out), 256'(0));
    chk("rst_b_busy", 256'(if_b.busy), 256'(0));
    chk("rst_b_ready", 256'(if_b.ready_in), 256'(1));
    chk("rst_c_state", if_c.state_out, 256'(0));
    @(posedge clk); #1;
    reset = 0;

    // pin the model with hand-computed values
    chk("model_enc",
        ref_shift(256'(128'hd42711aee0bf98f1b8b45de51e415230), 4, 0),
        256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    chk("model_dec",
        ref_shift(256'(128'hd4bf5d30e0b452aeb84111f11e2798e5), 4, 1),
        256'(128'hd42711aee0bf98f1b8b45de51e415230));
    for (int k = 0; k < 32; k++) s8[255-8*k -: 8] = 8'(k);
    m = ref_shift(s8, 8, 0);
    chk("model_nb8_r2", 256'(m[239 -: 8]), 256'(8'h0e));
    chk("model_nb8_r3", 256'(m[231 -: 8]), 256'(8'h13));

    // STAGES=1 encrypt then decrypt, back to back
    @(posedge clk); #1;
    if_a.valid_in = 1; if_a.decrypt_in = 0;
    if_a.state_in = 128'hd42711aee0bf98f1b8b45de51e415230;
    @(posedge clk); #1;
    chk("a_enc_valid", 256'(if_a.valid_out), 256'(1));
    chk("a_enc_state", 256'(if_a.state_out),
        256'(128'hd4bf5d30e0b452aeb84111f11e2798e5));
    if_a.decrypt_in = 1;
    if_a.state_in = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
    @(posedge clk); #1;
    chk("a_dec_valid", 256'(if_a.valid_out), 256'(1));
    chk("a_dec_state", 256'(if_a.state_out),
        256'(128'hd42711aee0bf98f1b8b45de51e415230));
    if_a.valid_in = 0;
    @(posedge clk); #1;
    chk("a_drain", 256'(if_a.valid_out), 256'(0));

    // STAGES=3: 10 back-to-back beats, alternating direction
    first = -1; nvalid = 0;
    for (int t = 0; t < 16; t++) begin
      if (if_b.valid_out) begin
        if (first < 0) first = t;
        nvalid++;
        if (t > 12) chk("b_extra_valid", 256'(t), 256'(12));
      end
      if (t < 10) begin
        sa = {$urandom, $urandom, $urandom, $urandom};
        if_b.valid_in = 1;
        if_b.decrypt_in = t[0];
        if_b.state_in = sa;
      end else begin
        if_b.valid_in = 0;
      end
      @(posedge clk); #1;
    end
    chk("b_latency", 256'(first), 256'(3));
    chk("b_count", 256'(nvalid), 256'(10));

    // STAGES=3: 5-cycle stall mid-stream, 12 beats
    n = 0; s = 0;
    while (n < 12 && s < 40) begin
      sa = {$urandom, $urandom, $urandom, $urandom};
      if_b.valid_in = 1;
      if_b.decrypt_in = 1'($urandom_range(1));
      if_b.state_in = sa;
      if_b.ready_out = !(s >= 4 && s < 9);
      #1;
      acc = if_b.ready_in;
      if (s == 4) chk("b_stall_rdy_fall", 256'(acc), 256'(0));
      if (s == 8) chk("b_stall_rdy_low", 256'(acc), 256'(0));
      @(posedge clk); #1;
      if (acc) n++;
      s++;
    end
    chk("b_stall_beats", 256'(n), 256'(12));
    if_b.valid_in = 0; if_b.ready_out = 1;
    repeat (6) @(posedge clk);
    #1;

    // NB=8 encrypt of bytes 00..1f
    if_c.valid_in = 1; if_c.decrypt_in = 0; if_c.state_in = s8;
    @(posedge clk); #1;
    if_c.valid_in = 0;
    for (int i = 0; i < 10 && !if_c.valid_out; i++) begin
      @(posedge clk); #1;
    end
    chk("c_valid", 256'(if_c.valid_out), 256'(1));
    m = if_c.state_out;
    chk("c_r2c0", 256'(m[239 -: 8]), 256'(8'h0e));
    chk("c_r3c0", 256'(m[231 -: 8]), 256'(8'h13));
    if_c.valid_in = 1; if_c.decrypt_in = 1; if_c.state_in = m;
    @(posedge clk); #1;
    if_c.valid_in = 0;
    repeat (4) @(posedge clk);
    #1;

    // reset with 2 beats in flight on STAGES=3
    if_b.valid_in = 1; if_b.decrypt_in = 0;
    if_b.state_in = 128'h00112233445566778899aabbccddeeff;
    @(posedge clk); #1;
    if_b.state_in = 128'hffeeddccbbaa99887766554433221100;
    @(posedge clk); #1;
    if_b.valid_in = 0;
    reset = 1;
    #1;
    chk("rr_valid", 256'(if_b.valid_out), 256'(0));
    chk("rr_state", 256'(if_b.state_out), 256'(0));
    chk("rr_busy", 256'(if_b.busy), 256'(0));
    chk("rr_ready", 256'(if_b.ready_in), 256'(1));
    @(posedge clk); #1;
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      chk("rr_no_stale", 256'(if_b.valid_out), 256'(0));
      @(posedge clk); #1;
    end

    chk("sq_a_empty", 256'(sq[0].size()), 256'(0));
    chk("sq_b_empty", 256'(sq[1].size()), 256'(0));
    chk("sq_c_empty", 256'(sq[2].size()), 256'(0));
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_shift_rows_pipe.md
Name: aes_shift_rows_pipe

Overview:
Parametrised, pipelined successor to the combinational ShiftRows stage. Performs ShiftRows (encrypt) or InvShiftRows (decrypt), selected per beat, on Rijndael states of NB columns. Output passes through STAGES elastic registers with valid/ready backpressure. Sits between the SubBytes and MixColumns stages of the round datapath.

Parameters:
NB, 4, state columns (legal 4, 6, 8); state width W = 32*NB
STAGES, 1, register stages (legal 1..4)
TAG_W, 4, sideband tag width (used only with optional feature)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
valid_in  in  1  input beat valid
ready_in  out  1  block can accept a beat this cycle
decrypt_in  in  1  1 = InvShiftRows, 0 = ShiftRows (sampled with beat)
state_in  in  W  input state
valid_out  out  1  output beat valid
ready_out  in  1  downstream accepts output
state_out  out  W  shifted state
busy  out  1  any stage holds a valid beat

Behaviour:
- Byte map: byte k occupies state[W-1-8k -: 8]; row r = k mod 4, column c = k div 4 (column-major, byte 0 at MSB).
- Row offsets: NB=4 or 6 -> {0,1,2,3}; NB=8 -> {0,1,3,4}.
- Encrypt: out(r,c) = in(r,(c+off_r) mod NB). Decrypt: out(r,c) = in(r,(c-off_r+NB) mod NB).
- Shift is combinational into stage 0 register; stages 1..STAGES-1 are plain pipeline registers. Each stage holds data, valid bit.
- Stage i loads when !valid_i or stage i+1 loads (last stage: ready_out). ready_in = !valid_0 or stage 0 loads. Transfer occurs when valid and ready both high.
- Latency STAGES cycles with ready_out held high; throughput one beat per cycle; no bubbles inserted.
- ready_out low: beats stall in place, no drops, no duplicates; bubbles collapse (stage fills while downstream stalled if empty).
- valid_out/state_out stable while valid_out=1 and ready_out=0.
- ready_in may depend combinationally on ready_out (no skid buffer); valid_in must not depend on ready_in.
- Data registers of stages without valid beats hold previous value; state_out reflects last stage register.
- busy = OR of all stage valid bits.
- Reset (async assert, sync-released by top): all valid bits 0, all data registers 0 -> valid_out=0, state_out=0, busy=0, ready_in=1. Reset mid-operation drops all in-flight beats.
- Illegal NB or STAGES: elaboration-time error.

Optional Feature:
Macro AES_SHIFT_ROWS_TAG_EN. Defined: ports tag_in (in, TAG_W) and tag_out (out, TAG_W) added; tag travels with its beat through every stage, reset value 0, unchanged by shifting. Not defined: ports absent, no tag registers.

Decomposition:
- Shared package aes_pkg: byte-index function (row, col, NB), row-offset function per NB, legal NB/STAGES constants.
- One sub-module natural: aes_shift_rows_comb (NB param, decrypt input, pure combinational permutation), instantiated once ahead of stage 0.

Test Plan:
- NB=4, STAGES=1, encrypt, state_in=d42711aee0bf98f1b8b45de51e415230, ready_out=1 -> next cycle valid_out=1, state_out=d4bf5d30e0b452aeb84111f11e2798e5.
- Same config, decrypt, state_in=d4bf5d30e0b452aeb84111f11e2798e5 -> state_out=d42711aee0bf98f1b8b45de51e415230.
- STAGES=3, 10 back-to-back beats with alternating decrypt_in, ready_out=1 -> outputs in order, first valid_out 3 cycles after first beat, 10 consecutive valid cycles.
- STAGES=3, ready_out low for 5 cycles mid-stream -> ready_in falls once 3 beats are held, state_out stable, no loss or duplication after release.
- NB=8, encrypt, state_in bytes 00..1f -> row 2 shifted by 3, row 3 by 4: out byte (r=2,c=0)=0e, out byte (r=3,c=0)=13.
- Assert reset with 2 beats in flight -> valid_out=0, state_out=0, busy=0, ready_in=1 immediately, no stale beat after release.
